if_id_skid: RTL and testbench

Fetch-to-decode pipeline stage of the RISC-V core; sits directly upstream of immgen.
- Accepts fetched {pc, instr} words over a valid/ready handshake.
- Buffers them in a 2-entry skid buffer and pre-decodes the opcode into imm_sel.
- Presents registered instr[31:7] + imm_sel to immgen, plus pc/instr to the rest of decode.
- Fully registered outputs break the fetch→decode timing path.

---
 rtl/if_id_skid_pkg.sv | 38 +++
 rtl/if_id_skid_if.sv | 24 ++
 rtl/if_id_skid_imm_sel_decode.sv | 23 ++
 rtl/if_id_skid.sv | 120 ++++++++++++
 tb/tb_if_id_skid.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared opcode, immediate-type and stage-state encodings for if_id_skid
package if_id_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic        illegal;
  } decoded_t;

  function automatic decoded_t nop_entry(input logic [31:0] nop);
    nop_entry = '{instr: nop, imm_sel: IMM_I, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// rtl/if_id_skid_if.sv - fetch-side and decode-side handshake bundle of the if_id_skid stage
interface if_id_skid_if #(parameter int PC_W = 32);
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_valid;
  logic            id_ready;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [24:0]     id_imm_field;
  logic [2:0]      id_imm_sel;
  logic            id_illegal;

  modport master (
    output if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_imm_field, id_imm_sel, id_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_imm_field, id_imm_sel, id_illegal
  );
endinterface

// File: rtl/if_id_skid_imm_sel_decode.sv
// rtl/if_id_skid_imm_sel_decode.sv - opcode to {imm_sel, illegal} pre-decode
module imm_sel_decode
  import if_id_skid_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  always_comb begin
    imm_sel = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_OP, OP_FENCE: imm_sel = IMM_I;
      OP_STORE:           imm_sel = IMM_S;
      OP_BRANCH:          imm_sel = IMM_B;
      OP_LUI, OP_AUIPC:   imm_sel = IMM_U;
      OP_JAL:             imm_sel = IMM_J;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - 2-entry registered fetch-to-decode skid stage with opcode pre-decode
// Optional IF_ID_PERF_EN adds saturating stall_cycles/bubble_cycles counters.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  if_id_skid_if.slave bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles
`endif
);

  state_t          state, state_next;
  logic            ready_q, ready_next;
  decoded_t        head, head_next, skid, skid_next, in_entry;
  logic [PC_W-1:0] head_pc, head_pc_next, skid_pc, skid_pc_next;
  logic [2:0]      in_sel;
  logic            in_illegal;
  logic            valid, accept, deliver;

  imm_sel_decode u_dec (
    .opcode  (bus.if_instr[6:0]),
    .imm_sel (in_sel),
    .illegal (in_illegal)
  );

  assign in_entry = {bus.if_instr, in_sel, in_illegal};
  assign valid    = (state != EMPTY);
  assign accept   = bus.if_valid && ready_q;
  assign deliver  = valid && bus.id_ready;

  always_comb begin
    state_next   = state;
    head_next    = head;
    head_pc_next = head_pc;
    skid_next    = skid;
    skid_pc_next = skid_pc;
    if (flush) begin
      state_next   = EMPTY;
      head_next    = nop_entry(NOP_INSTR);
      head_pc_next = '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_next   = ONE;
          head_next    = in_entry;
          head_pc_next = bus.if_pc;
        end
        ONE: if (accept && deliver) begin
          head_next    = in_entry;
          head_pc_next = bus.if_pc;
        end else if (accept) begin
          state_next   = FULL;
          skid_next    = in_entry;
          skid_pc_next = bus.if_pc;
        end else if (deliver) begin
          state_next   = EMPTY;
          head_next    = nop_entry(NOP_INSTR);
          head_pc_next = '0;
        end
        FULL: if (deliver) begin
          state_next   = ONE;
          head_next    = skid;
          head_pc_next = skid_pc;
        end
        default: state_next = EMPTY;
      endcase
    end
    // Registered ready: derived from next state so id_ready never reaches if_ready combinationally
    ready_next = (state_next != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      head    <= nop_entry(NOP_INSTR);
      head_pc <= '0;
      skid    <= nop_entry(NOP_INSTR);
      skid_pc <= '0;
    end else begin
      state   <= state_next;
      ready_q <= ready_next;
      head    <= head_next;
      head_pc <= head_pc_next;
      skid    <= skid_next;
      skid_pc <= skid_pc_next;
    end
  end

  assign bus.if_ready     = ready_q;
  assign bus.id_valid     = valid;
  assign bus.id_pc        = head_pc;
  assign bus.id_instr     = head.instr;
  assign bus.id_imm_field = head.instr[31:7];
  assign bus.id_imm_sel   = head.imm_sel;
  assign bus.id_illegal   = head.illegal;

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (valid && !bus.id_ready && stall_cycles != 32'hFFFFFFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (!valid && bus.id_ready && bubble_cycles != 32'hFFFFFFFF)
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed self-checking bench for if_id_skid
module tb_if_id_skid;

  localparam logic [2:0]  E_IMM_I = 3'd0;
  localparam logic [2:0]  E_IMM_S = 3'd1;
  localparam logic [2:0]  E_IMM_B = 3'd2;
  localparam logic [2:0]  E_IMM_U = 3'd3;
  localparam logic [2:0]  E_IMM_J = 3'd4;
  localparam logic [31:0] E_NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   fails  = 0;

  if_id_skid_if #(.PC_W(32)) bus ();

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  if_id_skid #(.PC_W(32), .NOP_INSTR(32'h00000013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.id_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL reset_if_ready got %b want 1", bus.if_ready); end
    checks++; if (bus.id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc got %h want 0", bus.id_pc); end
    checks++; if (bus.id_instr !== E_NOP) begin fails++; $display("FAIL reset_id_instr got %h want %h", bus.id_instr, E_NOP); end
    checks++; if (bus.id_imm_field !== 25'h0) begin fails++; $display("FAIL reset_imm_field got %h want 0", bus.id_imm_field); end
    checks++; if (bus.id_imm_sel !== E_IMM_I) begin fails++; $display("FAIL reset_imm_sel got %0d want %0d", bus.id_imm_sel, E_IMM_I); end
    checks++; if (bus.id_illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal got %b want 0", bus.id_illegal); end
  endtask

  task automatic test_basic();
    bus.id_ready = 1'b1;
    offer(32'h0, 32'h00100093);
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", bus.id_valid); end
    checks++; if (bus.id_imm_field !== 25'h0002001) begin fails++; $display("FAIL basic_imm_field got %h want 0002001", bus.id_imm_field); end
    checks++; if (bus.id_imm_sel !== E_IMM_I) begin fails++; $display("FAIL basic_imm_sel got %0d want %0d", bus.id_imm_sel, E_IMM_I); end
    checks++; if (bus.id_illegal !== 1'b0) begin fails++; $display("FAIL basic_illegal got %b want 0", bus.id_illegal); end
    checks++; if (bus.id_instr !== 32'h00100093) begin fails++; $display("FAIL basic_instr got %h want 00100093", bus.id_instr); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL basic_drain_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.id_instr !== E_NOP) begin fails++; $display("FAIL basic_drain_instr got %h want %h", bus.id_instr, E_NOP); end
  endtask

  task automatic test_backpressure();
    bus.id_ready = 1'b0;
    offer(32'h4, 32'h00102123);
    step();
    checks++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one got %b want 1", bus.if_ready); end
    offer(32'h8, 32'h00100263);
    step();
    checks++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %b want 0", bus.if_ready); end
    offer(32'hC, 32'h00001097);
    step();
    checks++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_hold got %b want 0", bus.if_ready); end
    checks++; if (bus.id_pc !== 32'h4 || bus.id_imm_sel !== E_IMM_S) begin fails++; $display("FAIL bp_head_stable got pc %h sel %0d want pc 4 sel %0d", bus.id_pc, bus.id_imm_sel, E_IMM_S); end
    bus.id_ready = 1'b1;
    step();
    checks++; if (bus.id_pc !== 32'h8 || bus.id_imm_sel !== E_IMM_B) begin fails++; $display("FAIL bp_second got pc %h sel %0d want pc 8 sel %0d", bus.id_pc, bus.id_imm_sel, E_IMM_B); end
    checks++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_pc !== 32'hC || bus.id_imm_sel !== E_IMM_U || bus.id_valid !== 1'b1) begin fails++; $display("FAIL bp_third got pc %h sel %0d valid %b want pc c sel %0d valid 1", bus.id_pc, bus.id_imm_sel, bus.id_valid, E_IMM_U); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", bus.id_valid); end
  endtask

  task automatic test_back_to_back();
    bus.id_ready = 1'b1;
    offer(32'h0, 32'h00000013);
    step();
    for (int i = 1; i <= 4; i++) begin
      offer(32'(4 * i), 32'h00100093);
      step();
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * i) || bus.if_ready !== 1'b1) begin fails++; $display("FAIL b2b_%0d got valid %b pc %h ready %b want 1 %h 1", i, bus.id_valid, bus.id_pc, bus.if_ready, 32'(4 * i)); end
    end
    bus.if_valid = 1'b0;
    step();
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", bus.id_valid); end
  endtask

  task automatic test_flush();
    bus.id_ready = 1'b0;
    offer(32'h20, 32'h00000013);
    step();
    offer(32'h24, 32'h00000013);
    step();
    checks++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full got %b want 0", bus.if_ready); end
    flush = 1'b1;
    offer(32'h28, 32'h008000ef);
    step();
    flush = 1'b0;
    bus.if_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %b want 1", bus.if_ready); end
    checks++; if (bus.id_instr !== E_NOP) begin fails++; $display("FAIL flush_instr got %h want %h", bus.id_instr, E_NOP); end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL flush_no_deliver_%0d got %b want 0", i, bus.id_valid); end
    end
  endtask

  task automatic test_illegal();
    bus.id_ready = 1'b0;
    offer(32'h40, 32'h00000000);
    step();
    checks++; if (bus.id_illegal !== 1'b1 || bus.id_imm_sel !== E_IMM_I) begin fails++; $display("FAIL illegal_zero got ill %b sel %0d want 1 %0d", bus.id_illegal, bus.id_imm_sel, E_IMM_I); end
    bus.id_ready = 1'b1;
    offer(32'h44, 32'h00000033);
    step();
    checks++; if (bus.id_illegal !== 1'b0 || bus.id_imm_sel !== E_IMM_I || bus.id_instr !== 32'h00000033) begin fails++; $display("FAIL illegal_rtype got ill %b sel %0d instr %h want 0 %0d 00000033", bus.id_illegal, bus.id_imm_sel, bus.id_instr, E_IMM_I); end
    offer(32'h48, 32'h008000ef);
    step();
    checks++; if (bus.id_imm_sel !== E_IMM_J || bus.id_imm_field !== 25'h0010001) begin fails++; $display("FAIL jal_decode got sel %0d field %h want %0d 0010001", bus.id_imm_sel, bus.id_imm_field, E_IMM_J); end
    bus.if_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.id_ready = 1'b0;
    offer(32'h50, 32'h00100093);
    step();
    offer(32'h54, 32'h00102123);
    step();
    rst_n = 1'b0;
    offer(32'h58, 32'h00100263);
    step();
    rst_n = 1'b1;
    bus.if_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin fails++; $display("FAIL rstmid_flags got valid %b ready %b want 0 1", bus.id_valid, bus.if_ready); end
    checks++; if (bus.id_pc !== 32'h0 || bus.id_instr !== E_NOP || bus.id_illegal !== 1'b0 || bus.id_imm_sel !== E_IMM_I) begin fails++; $display("FAIL rstmid_regs got pc %h instr %h ill %b sel %0d want 0 %h 0 %0d", bus.id_pc, bus.id_instr, bus.id_illegal, bus.id_imm_sel, E_NOP, E_IMM_I); end
`ifdef IF_ID_PERF_EN
    checks++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0) begin fails++; $display("FAIL perf_reset got stall %0d bubble %0d want 0 0", stall_cycles, bubble_cycles); end
`endif
    bus.id_ready = 1'b1;
    step();
    checks++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale got %b want 0", bus.id_valid); end
`ifdef IF_ID_PERF_EN
    bus.id_ready = 1'b0;
    offer(32'h60, 32'h00100093);
    step();
    bus.if_valid = 1'b0;
    repeat (5) step();
    checks++; if (stall_cycles !== 32'd5) begin fails++; $display("FAIL perf_stall got %0d want 5", stall_cycles); end
    checks++; if (bubble_cycles !== 32'd1) begin fails++; $display("FAIL perf_bubble got %0d want 1", bubble_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
